// File: rtl/nand_seq_pkg.sv
// nand_seq_pkg: shared state encoding, ONFI opcodes and address-cycle limit for the NAND command sequencer.
package nand_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD1, S_ADDR, S_WDATA, S_CMD2, S_TWB, S_WAIT_RB, S_RDATA, S_DONE
    } state_t;

    localparam logic [7:0] OP_READ       = 8'h00;
    localparam logic [7:0] OP_READ_CONF  = 8'h30;
    localparam logic [7:0] OP_ERASE      = 8'h60;
    localparam logic [7:0] OP_STATUS     = 8'h70;
    localparam logic [7:0] OP_PROG       = 8'h80;
    localparam logic [7:0] OP_READ_ID    = 8'h90;
    localparam logic [7:0] OP_PROG_CONF  = 8'h10;
    localparam logic [7:0] OP_ERASE_CONF = 8'hD0;
    localparam logic [7:0] OP_RESET      = 8'hFF;

    localparam int MAX_ADDR_CYC = 5;

    function automatic logic [2:0] clamp_naddr(input logic [2:0] n);
        return (n > 3'(MAX_ADDR_CYC)) ? 3'(MAX_ADDR_CYC) : n;
    endfunction

endpackage

// File: rtl/nand_cmd_sequencer_strobe.sv
// nand_strobe_gen: one strobe cycle, low for TWP_CYC then high for TWH_CYC clocks.
// A strobe begins in the same clock that start is seen while idle; start is ignored mid-strobe.
module nand_strobe_gen #(
    parameter int TWP_CYC = 2,
    parameter int TWH_CYC = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic start,
    input  logic is_read,
    output logic strobe_n,
    output logic sample,
    output logic last,
    output logic busy
);

    localparam int TOT = TWP_CYC + TWH_CYC;
    localparam int CW  = $clog2(TOT);

    logic [CW-1:0] cnt, cur;
    logic          active;

    always_comb begin
        active   = start | busy;
        cur      = busy ? cnt : '0;
        strobe_n = !(active && cur < CW'(TWP_CYC));
        sample   = active && is_read && cur == CW'(TWP_CYC - 1);
        last     = active && cur == CW'(TOT - 1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (active) begin
            busy <= !last;
            cnt  <= last ? '0 : cur + CW'(1);
        end
    end

endmodule

// File: rtl/nand_cmd_sequencer.sv
// nand_cmd_sequencer: ONFI async-mode host sequencer (cmd1, addr, wdata, cmd2, tWB, R/B# wait, rdata).
// Optional R/B# timeout when NAND_SEQ_RB_TIMEOUT_EN is defined (adds RB_TIMEOUT_CYC and rb_timeout).
module nand_cmd_sequencer
    import nand_seq_pkg::*;
#(
    parameter int DQ_BITS  = 8,
    parameter int TWP_CYC  = 2,
    parameter int TWH_CYC  = 2,
    parameter int TWB_CYC  = 8,
    parameter int NBYTES_W = 13
`ifdef NAND_SEQ_RB_TIMEOUT_EN
    , parameter int RB_TIMEOUT_CYC = 1 << 20
`endif
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_cmd1,
    input  logic [39:0]         req_addr,
    input  logic [2:0]          req_naddr,
    input  logic                req_cmd2_en,
    input  logic [7:0]          req_cmd2,
    input  logic                req_wait_rb,
    input  logic                req_rd,
    input  logic [NBYTES_W-1:0] req_nbytes,
    input  logic [DQ_BITS-1:0]  wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DQ_BITS-1:0]  rd_data,
    output logic                rd_valid,
    output logic                done,
    output logic [DQ_BITS-1:0]  Dq_Out,
    output logic                Dq_Oe,
    input  logic [DQ_BITS-1:0]  Dq_In,
    output logic                Cle,
    output logic                Ale,
    output logic                Ce_n,
    output logic                Clk_We_n,
    output logic                Wr_Re_n,
    output logic                Wp_n,
    input  logic                Rb_n
`ifdef NAND_SEQ_RB_TIMEOUT_EN
    , output logic              rb_timeout
`endif
);

`ifdef NAND_SEQ_RB_TIMEOUT_EN
    localparam int TCW = $clog2(RB_TIMEOUT_CYC > TWB_CYC ? RB_TIMEOUT_CYC : TWB_CYC) + 1;
`else
    localparam int TCW = $clog2(TWB_CYC) + 1;
`endif

    state_t                state, nxt, s_ad, s_wd, s_c2, s_tw, s_rd;
    logic                  rdy, wp, rb_m, rb_s;
    logic [7:0]            cmd1_q, cmd2_q;
    logic [39:0]           addr_q;
    logic [2:0]            nad;
    logic                  cmd2_en_q, wait_q, rd_q;
    logic [NBYTES_W-1:0]   cnt;
    logic [DQ_BITS-1:0]    wq;
    logic [TCW-1:0]        tcnt;
    logic                  strobe_n, sample, last, sbusy, start, is_read, drive, tinc, to_hit, accept;

    nand_strobe_gen #(.TWP_CYC(TWP_CYC), .TWH_CYC(TWH_CYC)) u_strobe (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .is_read(is_read),
        .strobe_n(strobe_n), .sample(sample), .last(last), .busy(sbusy)
    );

    // Phase skipping: each s_* is the first enabled phase at or after that point.
    always_comb begin
        s_rd     = (rd_q && cnt != '0) ? S_RDATA : S_DONE;
        s_tw     = wait_q ? S_TWB : s_rd;
        s_c2     = cmd2_en_q ? S_CMD2 : s_tw;
        s_wd     = (!rd_q && cnt != '0) ? S_WDATA : s_c2;
        s_ad     = (nad != '0) ? S_ADDR : s_wd;
        accept   = state == S_IDLE && req_valid && rdy;
        is_read  = state == S_RDATA;
        drive    = state inside {S_CMD1, S_ADDR, S_WDATA, S_CMD2};
        wr_ready = state == S_WDATA && !sbusy;
        start    = (state inside {S_CMD1, S_ADDR, S_CMD2, S_RDATA}) || (wr_ready && wr_valid);
        tinc     = state == S_TWB;
        to_hit   = 1'b0;
`ifdef NAND_SEQ_RB_TIMEOUT_EN
        tinc     = tinc || state == S_WAIT_RB;
        to_hit   = state == S_WAIT_RB && !rb_s && tcnt == TCW'(RB_TIMEOUT_CYC - 1);
`endif
        nxt = state;
        case (state)
            S_IDLE:    nxt = accept ? S_CMD1 : S_IDLE;
            S_CMD1:    nxt = last ? s_ad : state;
            S_ADDR:    nxt = (last && nad == 3'd1) ? s_wd : state;
            S_WDATA:   nxt = (last && cnt == NBYTES_W'(1)) ? s_c2 : state;
            S_CMD2:    nxt = last ? s_tw : state;
            S_TWB:     nxt = (tcnt == TCW'(TWB_CYC - 1)) ? S_WAIT_RB : state;
            S_WAIT_RB: nxt = rb_s ? s_rd : (to_hit ? S_IDLE : state);
            S_RDATA:   nxt = (last && cnt == NBYTES_W'(1)) ? S_DONE : state;
            default:   nxt = S_IDLE;
        endcase
        Cle       = state inside {S_CMD1, S_CMD2};
        Ale       = state == S_ADDR;
        Dq_Oe     = drive;
        Dq_Out    = state == S_CMD1  ? DQ_BITS'(cmd1_q) :
                    state == S_ADDR  ? DQ_BITS'(addr_q[7:0]) :
                    state == S_CMD2  ? DQ_BITS'(cmd2_q) :
                    state == S_WDATA ? (sbusy ? wq : wr_data) : '0;
        Ce_n      = !(drive || is_read || nxt == S_RDATA);
        Clk_We_n  = is_read | strobe_n;
        Wr_Re_n   = !is_read | strobe_n;
        done      = state == S_DONE || to_hit;
        req_ready = rdy;
        Wp_n      = wp;
`ifdef NAND_SEQ_RB_TIMEOUT_EN
        rb_timeout = to_hit;
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            rdy       <= 1'b0;
            wp        <= 1'b0;
            rb_m      <= 1'b1;
            rb_s      <= 1'b1;
            cmd1_q    <= '0;
            cmd2_q    <= '0;
            addr_q    <= '0;
            nad       <= '0;
            cmd2_en_q <= 1'b0;
            wait_q    <= 1'b0;
            rd_q      <= 1'b0;
            cnt       <= '0;
            wq        <= '0;
            tcnt      <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state    <= nxt;
            rdy      <= nxt == S_IDLE;
            rb_m     <= Rb_n;
            rb_s     <= rb_m;
            rd_valid <= sample;
            tcnt     <= (tinc && nxt == state) ? tcnt + TCW'(1) : '0;
            if (sample) rd_data <= Dq_In;
            if (wr_ready && wr_valid) wq <= wr_data;
            if (accept) begin
                wp        <= 1'b1;
                cmd1_q    <= req_cmd1;
                cmd2_q    <= req_cmd2;
                addr_q    <= req_addr;
                nad       <= clamp_naddr(req_naddr);
                cmd2_en_q <= req_cmd2_en;
                wait_q    <= req_wait_rb;
                rd_q      <= req_rd;
                cnt       <= req_nbytes;
            end
            if (state == S_ADDR && last) begin
                addr_q <= addr_q >> 8;
                nad    <= nad - 3'd1;
            end
            if ((state == S_WDATA || state == S_RDATA) && last) cnt <= cnt - NBYTES_W'(1);
        end
    end

endmodule
